modmul_barrett_seq: RTL and testbench

Parametrised sequential modular multiplier: computes t = (a·b) mod q with Barrett reduction over a W-bit datapath. It succeeds the fixed 64-bit multiply-then-reduce pair in the modular-arithmetic datapath. It adds:
- a valid/ready handshake on both sides;
- a fixed-latency multi-cycle schedule;
- synchronous reset;
- optional operand range checking.

---
 rtl/modmul_barrett_seq_if.sv | 28 ++
 rtl/modmul_barrett_seq.sv | 144 ++++++++++++++
 tb/tb_modmul_barrett_seq.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/modmul_barrett_seq_if.sv
// Operand/result handshake bundle for modmul_barrett_seq.
// The master side offers operands and consumes results; the slave side is the multiplier.
interface modmul_barrett_seq_if #(
  parameter int W  = 64,
  parameter int KW = 8
) ();
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  q;
  logic [W:0]    mu;
  logic [KW-1:0] k;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  t;
  logic          err;

  modport master (
    output in_valid, a, b, q, mu, k, out_ready,
    input  in_ready, out_valid, t, err
  );

  modport slave (
    input  in_valid, a, b, q, mu, k, out_ready,
    output in_ready, out_valid, t, err
  );
endinterface

// File: rtl/modmul_barrett_seq.sv
// Sequential Barrett modular multiplier t = (a*b) mod q, fixed latency, one operation in flight.
// Optional operand range checking is enabled by defining MODMUL_RANGE_CHECK_EN.
module modmul_barrett_seq #(
  parameter int W  = 64,
  parameter int KW = 8
) (
  input logic                clk,
  input logic                rst,
  modmul_barrett_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    Q2,
    RED,
    C1,
    C2,
    OUT
  } state_t;

  state_t          state;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [W-1:0]    q_r;
  logic [W:0]      mu_r;
  logic [KW-1:0]   k_r;
  logic [2*W-1:0]  z;
  logic [2*W+1:0]  q2;
  logic [W+1:0]    r;
  logic            bad_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic [W-1:0]    t_r;
  logic            err_r;

  logic            bad_in;
  logic [KW-1:0]   km1;
  logic [KW:0]     kp1;
  logic [W:0]      z_hi;
  logic [W+1:0]    q3_lo;
  logic [W+1:0]    q3q;
  logic [W+1:0]    q_ext;
  logic [2*W-1:0]  z_next;
  logic [2*W+1:0]  q2_next;
  logic [W+1:0]    r_next;
  logic [W+1:0]    r_corr;

`ifdef MODMUL_RANGE_CHECK_EN
  assign bad_in = (bus.a >= bus.q) || (bus.b >= bus.q) || (bus.q < W'(2)) ||
                  (bus.k == '0) || ({1'b0, bus.k} > (KW+1)'(W));
`else
  assign bad_in = 1'b0;
`endif

  // The reduction residue only needs W+2 bits because 0 <= r < 3q < 2^(W+2).
  assign km1     = k_r - KW'(1);
  assign kp1     = {1'b0, k_r} + (KW+1)'(1);
  assign z_next  = (2*W)'(a_r) * (2*W)'(b_r);
  assign z_hi    = (W+1)'(z >> km1);
  assign q2_next = (2*W+2)'(z_hi) * (2*W+2)'(mu_r);
  assign q3_lo   = (W+2)'(q2 >> kp1);
  assign q_ext   = {2'b00, q_r};
  assign q3q     = q3_lo * q_ext;
  assign r_next  = z[W+1:0] - q3q;
  assign r_corr  = (r >= q_ext) ? (r - q_ext) : r;

  // OUT spends its first cycle loading t/err, then holds them until the consumer takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      q_r         <= '0;
      mu_r        <= '0;
      k_r         <= '0;
      z           <= '0;
      q2          <= '0;
      r           <= '0;
      bad_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      t_r         <= '0;
      err_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            q_r        <= bus.q;
            mu_r       <= bus.mu;
            k_r        <= bus.k;
            bad_r      <= bad_in;
            in_ready_r <= 1'b0;
            state      <= MUL;
          end
        end
        MUL: begin
          z     <= z_next;
          state <= Q2;
        end
        Q2: begin
          q2    <= q2_next;
          state <= RED;
        end
        RED: begin
          r     <= r_next;
          state <= C1;
        end
        C1: begin
          r     <= r_corr;
          state <= C2;
        end
        C2: begin
          r     <= r_corr;
          state <= OUT;
        end
        OUT: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            t_r         <= bad_r ? '0 : r[W-1:0];
            err_r       <= bad_r;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.t         = t_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_modmul_barrett_seq.sv
// Self-checking bench for modmul_barrett_seq: directed vectors with literal results plus
// a reference model (plain (a*b) mod q) checked by a per-cycle monitor.
module tb_modmul_barrett_seq;
  localparam int W  = 64;
  localparam int KW = 8;

  typedef struct {
    logic [W-1:0] t;
    logic         err;
    logic         chk_t;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   cycle;
  int   accept_cycle;
  bit   started;
  bit   busy;
  bit   expect_idle;
  bit   prev_ov;
  bit   prev_handoff;
  bit   random_mode;
  logic [W-1:0] prev_t;
  logic         prev_err;
  exp_t exp_q[$];

  modmul_barrett_seq_if #(.W(W), .KW(KW)) bus ();

  modmul_barrett_seq #(.W(W), .KW(KW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic int bitlen(input logic [W-1:0] x);
    for (int i = W - 1; i >= 0; i--)
      if (x[i]) return i + 1;
    return 0;
  endfunction

  // Reference result straight from the arithmetic definition, not from the Barrett steps.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] q, input logic [KW-1:0] k);
    exp_t e;
    logic [127:0] p;
    bit bad;
    bad = (a >= q) || (b >= q) || (q < 2) || (k == 0) || (int'(k) > W);
    p = {64'b0, a} * {64'b0, b};
    e.t = (q != 0) ? W'(p % {64'b0, q}) : '0;
`ifdef MODMUL_RANGE_CHECK_EN
    e.err   = bad;
    e.chk_t = 1'b1;
    if (bad) e.t = '0;
`else
    e.err   = 1'b0;
    e.chk_t = !bad;
`endif
    return e;
  endfunction

  // Monitor: per-cycle protocol checks and model comparison at each hand-off.
  always @(negedge clk) begin
    exp_t e;
    bit handoff;
    cycle++;
    if (started) begin
      cmp("in_ready_vs_busy", bus.in_ready, !busy);
      if (expect_idle) cmp("out_valid_after_handoff", bus.out_valid, 1'b0);
      if (bus.out_valid && !prev_ov) cmp("latency_cycles", cycle - accept_cycle, 7);
      if (bus.out_valid && prev_ov && !prev_handoff) begin
        cmp("t_stable", bus.t, prev_t);
        cmp("err_stable", bus.err, prev_err);
      end
    end
    expect_idle = 1'b0;
    handoff = 1'b0;
    if (rst) begin
      exp_q.delete();
      busy = 1'b0;
    end else begin
      handoff = bus.out_valid && bus.out_ready;
      if (handoff) begin
        cmp("result_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (e.chk_t) cmp("t_model", bus.t, e.t);
          cmp("err_model", bus.err, e.err);
        end
        busy = 1'b0;
        expect_idle = 1'b1;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.q, bus.k));
        busy = 1'b1;
        accept_cycle = cycle;
      end
    end
    prev_ov = bus.out_valid;
    prev_t = bus.t;
    prev_err = bus.err;
    prev_handoff = handoff;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (random_mode) bus.out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] q, input logic [W:0] mu,
                               input logic [KW-1:0] k);
    int n;
    @(posedge clk);
    #1;
    bus.a = a;
    bus.b = b;
    bus.q = q;
    bus.mu = mu;
    bus.k = k;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 2000);
    if (!bus.in_ready) cmp("accept_timeout", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = rand64();
    bus.b = rand64();
    bus.q = rand64();
    bus.mu = {1'b1, rand64()};
    bus.k = KW'($urandom);
  endtask

  task automatic waitValid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 50);
    if (!bus.out_valid) cmp("out_valid_timeout", bus.out_valid, 1'b1);
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] exp_tv,
                             input logic exp_err, input bit chk_t);
    waitValid();
    if (chk_t) cmp({name, "_t"}, bus.t, exp_tv);
    cmp({name, "_err"}, bus.err, exp_err);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] m61;
    logic [W:0]   mu61;
    logic [W-1:0] rq;
    logic [128:0] num;
    int n;
    int sel;
    int kk;
    vectors = 0;
    miscompares = 0;
    cycle = 0;
    accept_cycle = 0;
    started = 1'b0;
    busy = 1'b0;
    random_mode = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.q = '0;
    bus.mu = '0;
    bus.k = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    cmp("reset_in_ready", bus.in_ready, 1'b1);
    cmp("reset_out_valid", bus.out_valid, 1'b0);
    cmp("reset_t", bus.t, 64'd0);
    cmp("reset_err", bus.err, 1'b0);
    started = 1'b1;

    // 3000 mod 97 = 90
    applyStimulus(64'd50, 64'd60, 64'd97, 65'd168, 8'd7);
    checkOutput("q97", 64'd90, 1'b0, 1'b1);

    // Mersenne 2^61-1: (q-1)^2 = 1, 2^70 = 2^9
    m61 = (64'd1 << 61) - 64'd1;
    mu61 = (65'd1 << 61) + 65'd1;
    applyStimulus(m61 - 64'd1, m61 - 64'd1, m61, mu61, 8'd61);
    checkOutput("m61_qm1sq", 64'd1, 1'b0, 1'b1);

    applyStimulus(64'd1 << 40, 64'd1 << 30, m61, mu61, 8'd61);
    waitValid();
    repeat (10) @(negedge clk);
    cmp("backpressure_in_ready", bus.in_ready, 1'b0);
    checkOutput("m61_pow2", 64'd512, 1'b0, 1'b1);

    // Abort while in Q2 (two edges after acceptance)
    applyStimulus(64'd50, 64'd60, 64'd97, 65'd168, 8'd7);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    cmp("abort_out_valid", bus.out_valid, 1'b0);
    cmp("abort_in_ready", bus.in_ready, 1'b1);
    cmp("abort_t", bus.t, 64'd0);
    applyStimulus(64'd50, 64'd60, 64'd97, 65'd168, 8'd7);
    checkOutput("after_abort", 64'd90, 1'b0, 1'b1);

    applyStimulus(64'd97, 64'd5, 64'd97, 65'd168, 8'd7);
`ifdef MODMUL_RANGE_CHECK_EN
    checkOutput("range_a_eq_q", 64'd0, 1'b1, 1'b1);
`else
    checkOutput("range_a_eq_q", 64'd0, 1'b0, 1'b0);
`endif

    random_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(2, W);
      rq = rand64() >> (W - sel);
      rq[sel-1] = 1'b1;
      kk = bitlen(rq);
      num = 129'd1 << (2 * kk);
      applyStimulus(rand64() % rq, rand64() % rq, rq, (W+1)'(num / {65'd0, rq}), KW'(kk));
    end
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    random_mode = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    cmp("final_busy", busy, 1'b0);
    cmp("no_lost_results", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
